// File: rtl/uart_pkg.sv
// Shared constants and types for the oversampled UART receiver.
package uart_pkg;

    // Parity selection encoding (3 behaves like none)
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Bit positions inside the 3-bit frame status word
    localparam int unsigned STATUS_BRK  = 2;
    localparam int unsigned STATUS_PERR = 1;
    localparam int unsigned STATUS_FERR = 0;
    localparam int unsigned STATUS_W    = 3;

    // Receiver frame states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } rx_state_e;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received frames; drops pushes when full and flags an overrun.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overrun
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overrun_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push+pop while full both succeed
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so stale entries never leak out
    assign rdata   = empty ? '0 : mem[rd_ptr_q];
    assign overrun = overrun_q;

    // Storage array write; contents need no reset since reads are gated by empty
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer, occupancy and overrun-pulse bookkeeping
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && !do_push;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_multi.sv
// Oversampled UART receiver with run-time frame format, error status and output FIFO.
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             uart_rx,
    output logic [7:0]       rx_data,
    output logic [2:0]       rx_status,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic             line_seen_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       bits_q;
    logic [1:0]       par_q;
    logic             stop2_q;
    logic [DIV_W-1:0] tick_cnt_q;
    logic [SW-1:0]    s_cnt_q;
    logic [1:0]       samp_q;
    logic [7:0]       data_q;
    logic [3:0]       bit_cnt_q;
    logic             par_bit_q;
    logic             zero_q;
    logic             ferr_q;
    logic             brk_q;

    logic             rxd;
    logic             fall;
    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic             vote_en;
    logic             vote;
    logic             bit_end;
    logic [3:0]       nbits;
    logic             par_on;
    logic             last_stop;
    logic             push;
    logic             brk_now;
    logic [2:0]       status_now;
    logic             fifo_empty;
    logic             fifo_full;
    logic [10:0]      fifo_rdata;

    assign rxd     = sync_q[0];
    assign fall    = sync_q[1] & ~sync_q[0];
    assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    assign tick    = (tick_cnt_q == div_eff - DIV_W'(1));
    assign vote_en = tick && (s_cnt_q == S_HI);
    assign vote    = maj3(samp_q[0], samp_q[1], rxd);
    assign bit_end = tick && (s_cnt_q == S_LAST);
    assign nbits   = {2'b00, bits_q} + 4'd5;
    assign par_on  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign rx_busy = (state_q != StIdle);

    assign last_stop = ((state_q == StStop1) && !stop2_q) || (state_q == StStop2);
    // Frame is pushed on the final stop-bit vote, mid-bit, so the next start edge is not missed
    assign push      = vote_en && last_stop;
    assign brk_now   = (state_q == StStop1) ? (zero_q & ~vote) : brk_q;

    // Status word for the frame being pushed, including the current stop-bit vote
    always_comb begin
        status_now              = '0;
        status_now[STATUS_BRK]  = brk_now;
        status_now[STATUS_FERR] = ferr_q | ~vote;
        status_now[STATUS_PERR] = par_on && ((^data_q ^ par_bit_q) ^ (par_q == PAR_ODD));
    end

    // Two-flop synchroniser; resets to idle-high so no edge is seen out of reset
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    // Arms start detection once the line has been high; a break disarms it
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            line_seen_q <= 1'b0;
        end else if (push && brk_now) begin
            line_seen_q <= 1'b0;
        end else if (rxd) begin
            line_seen_q <= 1'b1;
        end
    end

    // Baud tick divider, held at zero while idle so each frame starts phase-aligned
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else if ((state_q == StIdle) || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + DIV_W'(1);
        end
    end

    // Oversample position within the bit and the first two mid-bit samples
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            s_cnt_q <= '0;
            samp_q  <= 2'b00;
        end else if (state_q == StIdle) begin
            s_cnt_q <= '0;
        end else if (tick) begin
            s_cnt_q <= (s_cnt_q == S_LAST) ? '0 : s_cnt_q + SW'(1);
            if (s_cnt_q == S_LO) begin
                samp_q[0] <= rxd;
            end
            if (s_cnt_q == S_MID) begin
                samp_q[1] <= rxd;
            end
        end
    end

    // Frame FSM: config latch, data capture, parity and stop-bit checks
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bits_q    <= '0;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            par_bit_q <= 1'b0;
            zero_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (fall && line_seen_q) begin
                        state_q   <= StStart;
                        div_q     <= baud_div;
                        bits_q    <= cfg_bits;
                        par_q     <= cfg_parity;
                        stop2_q   <= cfg_stop2;
                        data_q    <= '0;
                        bit_cnt_q <= '0;
                        par_bit_q <= 1'b0;
                        zero_q    <= 1'b1;
                        ferr_q    <= 1'b0;
                        brk_q     <= 1'b0;
                    end
                end
                StStart: begin
                    if (vote_en && vote) begin
                        state_q <= StIdle;
                    end else if (bit_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (vote_en) begin
                        data_q[bit_cnt_q[2:0]] <= vote;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (vote) begin
                            zero_q <= 1'b0;
                        end
                    end else if (bit_end && (bit_cnt_q == nbits)) begin
                        state_q <= par_on ? StParity : StStop1;
                    end
                end
                StParity: begin
                    if (vote_en) begin
                        par_bit_q <= vote;
                        if (vote) begin
                            zero_q <= 1'b0;
                        end
                    end else if (bit_end) begin
                        state_q <= StStop1;
                    end
                end
                StStop1: begin
                    if (vote_en) begin
                        ferr_q <= ~vote;
                        brk_q  <= zero_q & ~vote;
                        if (!stop2_q) begin
                            state_q <= StIdle;
                        end
                    end else if (bit_end) begin
                        state_q <= StStop2;
                    end
                end
                StStop2: begin
                    if (vote_en) begin
                        ferr_q  <= ferr_q | ~vote;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (11),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .rst     (rst),
        .push    (push),
        .wdata   ({status_now, data_q}),
        .pop     (rx_ready),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .overrun (rx_overrun)
    );

    assign rx_data   = fifo_rdata[7:0];
    assign rx_status = fifo_rdata[10:8];
    assign rx_valid  = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed self-checking bench for uart_rx_multi.
module tb_uart_rx_multi;

    localparam int BAUD    = 27;
    localparam int BIT_CYC = BAUD * 16;

    logic        sysclk;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic [2:0]  rx_status;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_overrun;
    logic        rx_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_cnt  = 0;
    int ovr_base;

    uart_rx_multi #(
        .OVERSAMPLE (16),
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .baud_div   (baud_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_status  (rx_status),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Count overrun pulses as seen at each clock edge
    always @(posedge sysclk) begin
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        wait_cyc(BIT_CYC);
    endtask

    // par: 0 none, 1 even, 2 odd; flip_par inverts the transmitted parity bit
    task automatic send_frame(input logic [7:0] data, input int nbits, input int par,
                              input bit flip_par, input bit stop2_en, input bit stop2_val);
        logic ones;
        ones = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(data[i]);
            ones = ones ^ data[i];
        end
        if (par == 1) drive_bit(ones ^ flip_par);
        if (par == 2) drive_bit(~ones ^ flip_par);
        drive_bit(1'b1);
        if (stop2_en) drive_bit(stop2_val);
        uart_rx = 1'b1;
        wait_cyc(100);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        rst        = 1'b0;
        uart_rx    = 1'b1;
        rx_ready   = 1'b0;
        baud_div   = 16'(BAUD);
        cfg_bits   = 2'd3;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        wait_cyc(3);
        check("reset_valid",   rx_valid,   0);
        check("reset_data",    rx_data,    0);
        check("reset_status",  rx_status,  0);
        check("reset_busy",    rx_busy,    0);
        check("reset_overrun", rx_overrun, 0);
        rst = 1'b1;
        wait_cyc(5);

        // 8N1 0x55 with exact push latency: stop vote lands in the cycle before edge 4160
        uart_rx = 1'b0;
        wait_cyc(BIT_CYC);
        check("8n1_busy_mid", rx_busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(i % 2 == 0);
        uart_rx = 1'b1;
        wait_cyc(271);
        check("8n1_valid_before_push", rx_valid, 0);
        wait_cyc(1);
        check("8n1_valid_after_push", rx_valid, 1);
        check("8n1_busy_after_push",  rx_busy,  0);
        wait_cyc(160 + 100);
        check("8n1_data",   rx_data,   8'h55);
        check("8n1_status", rx_status, 3'b000);
        pop_one();
        check("8n1_popped", rx_valid, 0);

        // 7E1 0x3A, then the same frame with the parity bit flipped
        cfg_bits   = 2'd2;
        cfg_parity = 2'd1;
        send_frame(8'h3A, 7, 1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3A, 7, 1, 1'b1, 1'b0, 1'b1);
        check("7e1_data",       rx_data,   8'h3A);
        check("7e1_status",     rx_status, 3'b000);
        pop_one();
        check("7e1_bad_data",   rx_data,   8'h3A);
        check("7e1_bad_status", rx_status, 3'b010);
        pop_one();

        // 8N2 with the second stop bit low
        cfg_bits   = 2'd3;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b1;
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b0);
        check("8n2_data",   rx_data,   8'hA5);
        check("8n2_status", rx_status, 3'b001);
        pop_one();
        cfg_stop2 = 1'b0;

        // Two-cycle low glitch must be rejected as a false start
        uart_rx = 1'b0;
        wait_cyc(2);
        uart_rx = 1'b1;
        wait_cyc(10);
        check("glitch_busy",      rx_busy,  1);
        wait_cyc(BIT_CYC - 12);
        check("glitch_busy_done", rx_busy,  0);
        check("glitch_no_push",   rx_valid, 0);

        // Line held low for 20 bit times: one break entry only
        uart_rx = 1'b0;
        wait_cyc(15 * BIT_CYC);
        check("brk_valid",  rx_valid,  1);
        check("brk_data",   rx_data,   8'h00);
        check("brk_status", rx_status, 3'b101);
        pop_one();
        wait_cyc(5 * BIT_CYC);
        check("brk_single", rx_valid, 0);
        uart_rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        send_frame(8'h0F, 8, 0, 1'b0, 1'b0, 1'b1);
        check("post_brk_valid",  rx_valid,  1);
        check("post_brk_data",   rx_data,   8'h0F);
        check("post_brk_status", rx_status, 3'b000);
        pop_one();

        // Five frames into a depth-4 FIFO with no consumer
        ovr_base = ovr_cnt;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 0, 1'b0, 1'b0, 1'b1);
        check("ovr_pulses", 16'(ovr_cnt - ovr_base), 1);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_entry", rx_data, 16'(k));
            pop_one();
        end
        check("ovr_drained", rx_valid, 0);

        // Reset in the middle of a frame with one entry already queued
        send_frame(8'h81, 8, 0, 1'b0, 1'b0, 1'b1);
        uart_rx = 1'b0;
        wait_cyc(3 * BIT_CYC);
        check("mid_busy", rx_busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid",   rx_valid,   0);
        check("mid_rst_data",    rx_data,    0);
        check("mid_rst_status",  rx_status,  0);
        check("mid_rst_busy",    rx_busy,    0);
        check("mid_rst_overrun", rx_overrun, 0);
        uart_rx = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(5);
        send_frame(8'hC3, 8, 0, 1'b0, 1'b0, 1'b1);
        check("recover_data",   rx_data,   8'hC3);
        check("recover_status", rx_status, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
